// File: rtl/dbl_counter_pkg.sv
// Shared helpers for the dual-edge modulo counter family.
// Modular arithmetic is done on a fixed wide type (MAX_W+1 bits) so one set
// of functions serves every WIDTH up to MAX_W; callers slice the low bits.
package dbl_counter_pkg;

  // Widest count supported by the helpers below.
  localparam int MAX_W = 32;

  // One bit wider than the widest count, so a + b never overflows.
  typedef logic [MAX_W:0] wide_t;

  // Legal configuration: 1 <= width <= MAX_W and 2 <= modulus <= 2^width.
  function automatic bit modulus_ok(input int width, input longint modulus);
    return (width >= 1) && (width <= MAX_W) &&
           (modulus >= 2) && (modulus <= (longint'(1) << width));
  endfunction

  // (a + b) mod m, for a, b < m. The sum fits in MAX_W+1 bits.
  function automatic wide_t mod_add(input wide_t a, input wide_t b, input wide_t m);
    wide_t s;
    s = a + b;
    if (s >= m) begin
      s = s - m;
    end
    return s;
  endfunction

  // (a - b) mod m, for a, b < m. Never goes negative.
  function automatic wide_t mod_sub(input wide_t a, input wide_t b, input wide_t m);
    wide_t r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = (a + m) - b;
    end
    return r;
  endfunction

  // Reduce an arbitrary value into [0, m).
  function automatic wide_t mod_reduce(input wide_t a, input wide_t m);
    return a % m;
  endfunction

endpackage

// File: rtl/edge_half_counter.sv
// One modulo-MODULUS half-counter register, clocked on the rising edge
// (EDGE_POS = 1) or the falling edge (EDGE_POS = 0) of clk. A preset has
// priority over the enable; the falling-edge instance ties preset low.
module edge_half_counter
  import dbl_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter bit EDGE_POS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             preset,
  input  logic [WIDTH-1:0] preset_val,
  output logic [WIDTH-1:0] cnt
);

  localparam wide_t MOD_W = wide_t'(MODULUS);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  wide_t            inc_w;
  logic             unused_inc_hi;

  // Incremented value wraps at MODULUS; upper bits are always zero.
  assign inc_w         = mod_add(wide_t'(cnt_q), wide_t'(1), MOD_W);
  assign unused_inc_hi = ^inc_w[MAX_W:WIDTH];

  // Next state: preset wins over counting, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (preset) begin
      cnt_d = preset_val;
    end else if (enable) begin
      cnt_d = inc_w[WIDTH-1:0];
    end
  end

  generate
    if (EDGE_POS) begin : g_rise
      // Rising-edge state register with asynchronous clear.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_fall
      // Falling-edge state register with asynchronous clear.
      always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign cnt = cnt_q;

endmodule

// File: rtl/dual_edge_mod_counter.sv
// Modulo-MODULUS counter stepping on both clk edges (dbl = 1) or on the
// rising edge only (dbl = 0). The count is the modular sum of a rising-edge
// register and a falling-edge register, so each register has one clock edge.
// Clear and load act only on the rising-edge register, presetting it to the
// value that makes the sum come out right against the current falling half.
// Optional feature macro: DBLCNT_TC_EN enables the terminal-count output;
// without it tc is held at 0.
module dual_edge_mod_counter
  import dbl_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dbl,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam wide_t MOD_W = wide_t'(MODULUS);

  generate
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("dual_edge_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] p_cnt;
  logic [WIDTH-1:0] n_cnt;
  logic             p_preset;
  wide_t            load_red_w;
  wide_t            target_w;
  wide_t            preset_w;
  wide_t            sum_w;
  logic             unused_hi;

  // Value the count must show after this rising edge when presetting:
  // 0 for clear, the reduced load value otherwise.
  assign load_red_w = mod_reduce(wide_t'(load_val), MOD_W);
  assign target_w   = clear ? '0 : load_red_w;
  assign p_preset   = clear | load;

  // Solve p + n = target (mod MODULUS) for p using the current falling half.
  assign preset_w = mod_sub(target_w, wide_t'(n_cnt), MOD_W);

  edge_half_counter #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .EDGE_POS (1'b1)
  ) u_p_half (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .preset     (p_preset),
    .preset_val (preset_w[WIDTH-1:0]),
    .cnt        (p_cnt)
  );

  // The falling half only ever counts; it advances in dual mode only.
  edge_half_counter #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .EDGE_POS (1'b0)
  ) u_n_half (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable & dbl),
    .preset     (1'b0),
    .preset_val ('0),
    .cnt        (n_cnt)
  );

  // Visible count is the modular sum of the two halves, unregistered.
  assign sum_w = mod_add(wide_t'(p_cnt), wide_t'(n_cnt), MOD_W);
  assign count = sum_w[WIDTH-1:0];

  assign unused_hi = ^{sum_w[MAX_W:WIDTH], preset_w[MAX_W:WIDTH]};

`ifdef DBLCNT_TC_EN
  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(MODULUS - 1);

  // High during the step whose next enabled edge wraps to 0.
  assign tc = (count == TC_VAL) && enable;
`else
  assign tc = 1'b0;
`endif

endmodule

// File: tb/tb_dual_edge_mod_counter.sv
// Bench for dual_edge_mod_counter (WIDTH=4, MODULUS=10): directed scenarios
// with literal expectations, then randomized stimulus checked every half
// period against a count-level reference model.
module tb_dual_edge_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         enable   = 1'b0;
  logic         dbl      = 1'b0;
  logic         clear    = 1'b0;
  logic         load     = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tc;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_count = '0;

  dual_edge_mod_counter #(
    .WIDTH   (W),
    .MODULUS (M)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .dbl      (dbl),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int exp_tc_of(input int c, input logic en);
`ifdef DBLCNT_TC_EN
    return ((c == M - 1) && en) ? 1 : 0;
`else
    return (c < 0) ? 1 : 0;
`endif
  endfunction

  // Reference model: the visible count itself, stepped by the edge rules.
  always @(posedge clk or negedge clk or posedge reset) begin
    if (reset) begin
      exp_count <= '0;
    end else if (clk) begin
      if (clear)       exp_count <= '0;
      else if (load)   exp_count <= W'(int'(load_val) % M);
      else if (enable) exp_count <= W'((int'(exp_count) + 1) % M);
    end else begin
      if (enable && dbl) exp_count <= W'((int'(exp_count) + 1) % M);
    end
  end

  // Compare process: 4 time units after every clock edge.
  always begin
    @(clk);
    #4;
    check("model_count", int'(count), int'(exp_count));
    check("model_tc", int'(tc), exp_tc_of(int'(exp_count), enable));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int lit[12];
    lit = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    // Reset state.
    #2;
    check("reset_count", int'(count), 0);
    check("reset_tc", int'(tc), 0);

    // Dual-edge wrap: one step on every edge, tc only while count = 9.
    repeat (2) @(clk);
    #3;
    reset = 1'b0; enable = 1'b1; dbl = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(clk);
      #3;
      check("wrap_count", int'(count), lit[k]);
`ifdef DBLCNT_TC_EN
      check("wrap_tc", int'(tc), (lit[k] == 9) ? 1 : 0);
`else
      check("wrap_tc", int'(tc), 0);
`endif
    end

    // Single-edge mode: clear, then 5 rising edges give 5.
    @(posedge clk); #3;
    clear = 1'b1; enable = 1'b0;
    @(posedge clk); #3;
    check("clear_count", int'(count), 0);
    clear = 1'b0; dbl = 1'b0; enable = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    check("single_count", int'(count), 5);

    // Load while running: reach 7 with a nonzero falling half, load 3.
    dbl = 1'b1;
    @(posedge clk); #3;
    check("run_to_7", int'(count), 7);
    enable = 1'b0;
    @(negedge clk); #1;
    check("hold_7", int'(count), 7);
    load = 1'b1; load_val = 4'd3; enable = 1'b1;
    @(posedge clk); #1;
    check("load_count", int'(count), 3);
    load = 1'b0;
    @(negedge clk); #1;
    check("after_load_fall", int'(count), 4);

    // Clear, load and enable together: clear wins.
    clear = 1'b1; load = 1'b1; enable = 1'b1; load_val = 4'd5;
    @(posedge clk); #1;
    check("clear_prio", int'(count), 0);
    clear = 1'b0; load = 1'b0; enable = 1'b0;

    // Load value above the modulus is reduced.
    @(negedge clk); #1;
    load = 1'b1; load_val = 4'd13;
    @(posedge clk); #1;
    check("load_reduce", int'(count), 3);
    load = 1'b0;

    // Reset mid-count while clk is low.
    @(negedge clk); #1;
    load = 1'b1; load_val = 4'd6;
    @(posedge clk); #1;
    check("load_6", int'(count), 6);
    load = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("async_reset_count", int'(count), 0);
    check("async_reset_tc", int'(tc), 0);
    #1;
    reset = 1'b0; enable = 1'b1; dbl = 1'b1;
    @(posedge clk); #1;
    check("first_after_reset", int'(count), 1);

    // Randomized stimulus, checked by the compare process.
    for (int i = 0; i < 400; i++) begin
      @(clk);
      #3;
      reset    = ($urandom_range(0, 99) < 3);
      enable   = ($urandom_range(0, 9) != 0);
      dbl      = $urandom_range(0, 1) != 0;
      clear    = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom_range(0, 15));
    end
    reset = 1'b0;
    @(clk);
    #5;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
